// File: rtl/rs_multi_cdb_pkg.sv
// Shared constants for the multi-CDB reservation station: default sizes and
// the 7-bit RISC-V major opcodes carried through as op_type.
package rs_multi_cdb_pkg;

    localparam int RS_SIZE_DEF  = 8;
    localparam int ROB_BITS_DEF = 4;
    localparam int NUM_CDB_DEF  = 2;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } op_type_e;

endpackage

// File: rtl/rs_multi_cdb_if.sv
// Issue, CDB broadcast and dispatch bundle of the reservation station.
// master = issuing/broadcasting side, slave = the reservation station.
interface rs_multi_cdb_if
    import rs_multi_cdb_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int ROB_BITS = ROB_BITS_DEF,
    parameter int NUM_CDB  = NUM_CDB_DEF
);
    localparam int CW = $clog2(RS_SIZE + 1);

    logic                         issue_valid;
    logic [6:0]                   issue_op_type;
    logic [2:0]                   issue_op;
    logic                         issue_alt;
    logic [31:0]                  issue_v1;
    logic [31:0]                  issue_v2;
    logic                         issue_dep1;
    logic                         issue_dep2;
    logic [ROB_BITS-1:0]          issue_q1;
    logic [ROB_BITS-1:0]          issue_q2;
    logic [ROB_BITS-1:0]          issue_rd_rob;
    logic [31:0]                  issue_pc;

    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*ROB_BITS-1:0]  cdb_rob;
    logic [NUM_CDB*32-1:0]        cdb_value;

    logic                         disp_valid;
    logic [6:0]                   disp_op_type;
    logic [2:0]                   disp_op;
    logic                         disp_alt;
    logic [31:0]                  disp_v1;
    logic [31:0]                  disp_v2;
    logic [ROB_BITS-1:0]          disp_rob;
    logic [31:0]                  disp_pc;
    logic                         disp_ready;

    logic                         full;
    logic [CW-1:0]                count;

    modport master (
        output issue_valid, issue_op_type, issue_op, issue_alt, issue_v1, issue_v2,
               issue_dep1, issue_dep2, issue_q1, issue_q2, issue_rd_rob, issue_pc,
               cdb_valid, cdb_rob, cdb_value, disp_ready,
        input  disp_valid, disp_op_type, disp_op, disp_alt, disp_v1, disp_v2,
               disp_rob, disp_pc, full, count
    );

    modport slave (
        input  issue_valid, issue_op_type, issue_op, issue_alt, issue_v1, issue_v2,
               issue_dep1, issue_dep2, issue_q1, issue_q2, issue_rd_rob, issue_pc,
               cdb_valid, cdb_rob, cdb_value, disp_ready,
        output disp_valid, disp_op_type, disp_op, disp_alt, disp_v1, disp_v2,
               disp_rob, disp_pc, full, count
    );

endinterface

// File: rtl/rs_age_picker.sv
// Combinational picker: oldest ready entry by age matrix, and lowest free slot.
// older[i][j] set means entry i was issued before entry j.
module rs_age_picker #(
    parameter  int RS_SIZE = 8,
    localparam int IW      = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]              busy,
    input  logic [RS_SIZE-1:0]              ready,
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] older,
    output logic                            sel_valid,
    output logic [IW-1:0]                   sel_idx,
    output logic                            free_valid,
    output logic [IW-1:0]                   free_idx
);

    logic oldest;

    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        oldest     = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_valid = 1'b1;
                free_idx   = IW'(i);
            end
        end
        // An entry wins only if it is older than every other ready entry.
        for (int i = 0; i < RS_SIZE; i++) begin
            oldest = ready[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && ready[j] && !older[i][j]) begin
                    oldest = 1'b0;
                end
            end
            if (oldest) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station with several CDB wakeup ports, issue bypass and a
// one-deep dispatch register; oldest ready entry is dispatched first.
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int ROB_BITS = ROB_BITS_DEF,
    parameter int NUM_CDB  = NUM_CDB_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          rob_clear_up,
    rs_multi_cdb_if.slave bus
);

    localparam int IW = $clog2(RS_SIZE);
    localparam int CW = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0]              busy, dep1, dep2, ready, alt;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
    logic [ROB_BITS-1:0]             q1 [RS_SIZE];
    logic [ROB_BITS-1:0]             q2 [RS_SIZE];
    logic [ROB_BITS-1:0]             rob [RS_SIZE];
    logic [31:0]                     v1 [RS_SIZE];
    logic [31:0]                     v2 [RS_SIZE];
    logic [31:0]                     pc [RS_SIZE];
    logic [6:0]                      op_type [RS_SIZE];
    logic [2:0]                      op [RS_SIZE];
    logic [CW-1:0]                   count;

    logic                            disp_valid_q, disp_alt_q;
    logic [6:0]                      disp_op_type_q;
    logic [2:0]                      disp_op_q;
    logic [31:0]                     disp_v1_q, disp_v2_q, disp_pc_q;
    logic [ROB_BITS-1:0]             disp_rob_q;

    logic                            sel_valid, free_valid, full_w;
    logic [IW-1:0]                   sel_idx, free_idx;
    logic                            do_issue, load_en, take;
    logic [RS_SIZE-1:0]              wake1, wake2;
    logic [31:0]                     wake1_val [RS_SIZE];
    logic [31:0]                     wake2_val [RS_SIZE];
    logic                            byp1, byp2;
    logic [31:0]                     byp1_val, byp2_val;

    assign ready    = busy & ~dep1 & ~dep2;
    assign full_w   = (count == CW'(RS_SIZE));
    assign do_issue = rdy_in && bus.issue_valid && !full_w && free_valid;
    assign load_en  = rdy_in && (!disp_valid_q || bus.disp_ready);
    assign take     = load_en && sel_valid;

    rs_age_picker #(.RS_SIZE(RS_SIZE)) u_picker (
        .busy       (busy),
        .ready      (ready),
        .older      (older),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx),
        .free_valid (free_valid),
        .free_idx   (free_idx)
    );

    // Ports are scanned from the top down so the lowest matching port is the one left standing.
    always_comb begin
        wake1    = '0;
        wake2    = '0;
        byp1     = 1'b0;
        byp2     = 1'b0;
        byp1_val = '0;
        byp2_val = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1_val[i] = '0;
            wake2_val[i] = '0;
        end
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (bus.cdb_valid[k]) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (q1[i] == bus.cdb_rob[k*ROB_BITS +: ROB_BITS]) begin
                        wake1[i]     = 1'b1;
                        wake1_val[i] = bus.cdb_value[k*32 +: 32];
                    end
                    if (q2[i] == bus.cdb_rob[k*ROB_BITS +: ROB_BITS]) begin
                        wake2[i]     = 1'b1;
                        wake2_val[i] = bus.cdb_value[k*32 +: 32];
                    end
                end
                if (bus.issue_q1 == bus.cdb_rob[k*ROB_BITS +: ROB_BITS]) begin
                    byp1     = 1'b1;
                    byp1_val = bus.cdb_value[k*32 +: 32];
                end
                if (bus.issue_q2 == bus.cdb_rob[k*ROB_BITS +: ROB_BITS]) begin
                    byp2     = 1'b1;
                    byp2_val = bus.cdb_value[k*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy           <= '0;
            dep1           <= '0;
            dep2           <= '0;
            alt            <= '0;
            older          <= '0;
            count          <= '0;
            disp_valid_q   <= 1'b0;
            disp_alt_q     <= 1'b0;
            disp_op_type_q <= '0;
            disp_op_q      <= '0;
            disp_v1_q      <= '0;
            disp_v2_q      <= '0;
            disp_pc_q      <= '0;
            disp_rob_q     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                q1[i]      <= '0;
                q2[i]      <= '0;
                rob[i]     <= '0;
                v1[i]      <= '0;
                v2[i]      <= '0;
                pc[i]      <= '0;
                op_type[i] <= '0;
                op[i]      <= '0;
            end
        end else if (rob_clear_up) begin
            busy         <= '0;
            older        <= '0;
            count        <= '0;
            disp_valid_q <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && dep1[i] && wake1[i]) begin
                    v1[i]   <= wake1_val[i];
                    dep1[i] <= 1'b0;
                end
                if (busy[i] && dep2[i] && wake2[i]) begin
                    v2[i]   <= wake2_val[i];
                    dep2[i] <= 1'b0;
                end
            end
            // A new entry is younger than everything already present.
            if (do_issue) begin
                busy[free_idx]    <= 1'b1;
                dep1[free_idx]    <= bus.issue_dep1 && !byp1;
                dep2[free_idx]    <= bus.issue_dep2 && !byp2;
                v1[free_idx]      <= (bus.issue_dep1 && byp1) ? byp1_val : bus.issue_v1;
                v2[free_idx]      <= (bus.issue_dep2 && byp2) ? byp2_val : bus.issue_v2;
                q1[free_idx]      <= bus.issue_q1;
                q2[free_idx]      <= bus.issue_q2;
                rob[free_idx]     <= bus.issue_rd_rob;
                pc[free_idx]      <= bus.issue_pc;
                op_type[free_idx] <= bus.issue_op_type;
                op[free_idx]      <= bus.issue_op;
                alt[free_idx]     <= bus.issue_alt;
                for (int j = 0; j < RS_SIZE; j++) begin
                    older[j][free_idx] <= 1'b1;
                    older[free_idx][j] <= 1'b0;
                end
            end
            if (load_en) begin
                disp_valid_q <= sel_valid;
                if (sel_valid) begin
                    busy[sel_idx]  <= 1'b0;
                    disp_v1_q      <= v1[sel_idx];
                    disp_v2_q      <= v2[sel_idx];
                    disp_rob_q     <= rob[sel_idx];
                    disp_pc_q      <= pc[sel_idx];
                    disp_op_type_q <= op_type[sel_idx];
                    disp_op_q      <= op[sel_idx];
                    disp_alt_q     <= alt[sel_idx];
                end
            end
            count <= count + CW'(do_issue) - CW'(take);
        end
    end

    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_op_type = disp_op_type_q;
    assign bus.disp_op      = disp_op_q;
    assign bus.disp_alt     = disp_alt_q;
    assign bus.disp_v1      = disp_v1_q;
    assign bus.disp_v2      = disp_v2_q;
    assign bus.disp_rob     = disp_rob_q;
    assign bus.disp_pc      = disp_pc_q;
    assign bus.full         = full_w;
    assign bus.count        = count;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Scoreboard bench for rs_multi_cdb: expected dispatches are queued at issue
// and popped in order as the station presents them.
module tb_rs_multi_cdb;
    import rs_multi_cdb_pkg::*;

    localparam int RS_SIZE  = 8;
    localparam int ROB_BITS = 4;
    localparam int NUM_CDB  = 2;

    typedef struct {
        logic [ROB_BITS-1:0] rob;
        logic [31:0]         v1;
        logic [31:0]         v2;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic rob_clear_up;
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk_in = ~clk_in;

    rs_multi_cdb_if #(.RS_SIZE(RS_SIZE), .ROB_BITS(ROB_BITS), .NUM_CDB(NUM_CDB)) bus ();

    rs_multi_cdb #(.RS_SIZE(RS_SIZE), .ROB_BITS(ROB_BITS), .NUM_CDB(NUM_CDB)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear_up (rob_clear_up),
        .bus          (bus.slave)
    );

    function automatic logic [31:0] pc_of(input logic [3:0] r);
        return 32'h0000_1000 + {26'd0, r, 2'b00};
    endfunction

    function automatic logic [6:0] op_type_of(input logic [3:0] r);
        op_type_e t;
        t = r[0] ? OP_IMM : OP_REG;
        return t;
    endfunction

    function automatic logic alt_of(input logic [3:0] r);
        return r[3] ^ r[0];
    endfunction

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic drive_idle();
        bus.issue_valid   = 1'b0;
        bus.issue_op_type = '0;
        bus.issue_op      = '0;
        bus.issue_alt     = 1'b0;
        bus.issue_v1      = '0;
        bus.issue_v2      = '0;
        bus.issue_dep1    = 1'b0;
        bus.issue_dep2    = 1'b0;
        bus.issue_q1      = '0;
        bus.issue_q2      = '0;
        bus.issue_rd_rob  = '0;
        bus.issue_pc      = '0;
        bus.cdb_valid     = '0;
        bus.cdb_rob       = '0;
        bus.cdb_value     = '0;
        bus.disp_ready    = 1'b1;
    endtask

    task automatic drive_issue(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                               input logic d1, input logic [3:0] t1, input logic d2, input logic [3:0] t2);
        bus.issue_valid   = 1'b1;
        bus.issue_rd_rob  = r;
        bus.issue_v1      = a;
        bus.issue_v2      = b;
        bus.issue_dep1    = d1;
        bus.issue_q1      = t1;
        bus.issue_dep2    = d2;
        bus.issue_q2      = t2;
        bus.issue_pc      = pc_of(r);
        bus.issue_op_type = op_type_of(r);
        bus.issue_op      = r[2:0];
        bus.issue_alt     = alt_of(r);
    endtask

    task automatic push_exp(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.rob = r;
        e.v1  = a;
        e.v2  = b;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp_valid: got %b expected 0", bus.disp_valid); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.disp_v1 !== 32'd0 || bus.disp_rob !== 4'd0 || bus.disp_pc !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_disp_data: got v1=%h rob=%0d pc=%h expected all 0", bus.disp_v1, bus.disp_rob, bus.disp_pc);
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        int   seen_at = -1;
        drive_issue(4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        push_exp(4'd3, 32'd5, 32'd7);
        tick();
        bus.issue_valid = 1'b0;
        checks++; if (bus.count !== 4'd1) begin errors++; $display("[TB] FAIL single_count_after_issue: got %0d expected 1", bus.count); end
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                seen_at = c;
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2 || bus.disp_pc !== pc_of(e.rob) ||
                    bus.disp_op_type !== op_type_of(e.rob) || bus.disp_op !== e.rob[2:0] || bus.disp_alt !== alt_of(e.rob)) begin
                    errors++; $display("[TB] FAIL single_dispatch: got rob=%0d v1=%h v2=%h pc=%h opt=%h expected rob=%0d v1=%h v2=%h pc=%h opt=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, bus.disp_pc, bus.disp_op_type, e.rob, e.v1, e.v2, pc_of(e.rob), op_type_of(e.rob));
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL single_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
        checks++; if (seen_at != 1) begin errors++; $display("[TB] FAIL single_latency: got %0d cycles expected 1", seen_at); end
        checks++; if (bus.count !== 4'd0 || bus.disp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_drained: got count=%0d disp_valid=%b expected 0 and 0", bus.count, bus.disp_valid);
        end
    endtask

    task automatic test_wakeup();
        exp_t e;
        drive_issue(4'd1, 32'd0, 32'h22, 1'b1, 4'd2, 1'b0, 4'd0);
        tick();
        drive_issue(4'd5, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0);
        push_exp(4'd5, 32'h55, 32'h66);
        push_exp(4'd1, 32'h10, 32'h22);
        tick();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 2'b01;
        bus.cdb_rob     = {4'd0, 4'd2};
        bus.cdb_value   = {32'd0, 32'h10};
        tick();
        bus.cdb_valid = 2'b00;
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2 || bus.disp_pc !== pc_of(e.rob)) begin
                    errors++; $display("[TB] FAIL wakeup_order: got rob=%0d v1=%h v2=%h pc=%h expected rob=%0d v1=%h v2=%h pc=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, bus.disp_pc, e.rob, e.v1, e.v2, pc_of(e.rob));
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL wakeup_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_bypass();
        exp_t e;
        int   seen_at = -1;
        drive_issue(4'd7, 32'd0, 32'h77, 1'b1, 4'd6, 1'b0, 4'd0);
        bus.cdb_valid = 2'b11;
        bus.cdb_rob   = {4'd6, 4'd5};
        bus.cdb_value = {32'hAB, 32'hCC};
        push_exp(4'd7, 32'hAB, 32'h77);
        tick();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 2'b00;
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                seen_at = c;
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2) begin
                    errors++; $display("[TB] FAIL bypass_dispatch: got rob=%0d v1=%h v2=%h expected rob=%0d v1=%h v2=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, e.rob, e.v1, e.v2);
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL bypass_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
        checks++; if (seen_at != 1) begin errors++; $display("[TB] FAIL bypass_latency: got %0d cycles expected 1", seen_at); end
    endtask

    task automatic test_cdb_priority();
        exp_t e;
        drive_issue(4'd2, 32'd0, 32'd0, 1'b1, 4'd4, 1'b1, 4'd4);
        push_exp(4'd2, 32'd1, 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        checks++; if (bus.count !== 4'd1 || bus.disp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL priority_waiting: got count=%0d disp_valid=%b expected 1 and 0", bus.count, bus.disp_valid);
        end
        bus.cdb_valid = 2'b11;
        bus.cdb_rob   = {4'd4, 4'd4};
        bus.cdb_value = {32'd2, 32'd1};
        tick();
        bus.cdb_valid = 2'b00;
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2) begin
                    errors++; $display("[TB] FAIL priority_capture: got rob=%0d v1=%h v2=%h expected rob=%0d v1=%h v2=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, e.rob, e.v1, e.v2);
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL priority_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
    endtask

    // Younger entry lands in a lower slot than an older one; both wake together.
    task automatic test_age_order();
        exp_t e;
        bus.disp_ready = 1'b0;
        drive_issue(4'd1, 32'h11, 32'h12, 1'b0, 4'd0, 1'b0, 4'd0);
        push_exp(4'd1, 32'h11, 32'h12);
        tick();
        drive_issue(4'd2, 32'd0, 32'h22, 1'b1, 4'd9, 1'b0, 4'd0);
        push_exp(4'd2, 32'h99, 32'h22);
        tick();
        drive_issue(4'd3, 32'd0, 32'h33, 1'b1, 4'd9, 1'b0, 4'd0);
        push_exp(4'd3, 32'h99, 32'h33);
        tick();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 2'b01;
        bus.cdb_rob     = {4'd0, 4'd9};
        bus.cdb_value   = {32'd0, 32'h99};
        tick();
        bus.cdb_valid  = 2'b00;
        bus.disp_ready = 1'b1;
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2) begin
                    errors++; $display("[TB] FAIL age_order: got rob=%0d v1=%h v2=%h expected rob=%0d v1=%h v2=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, e.rob, e.v1, e.v2);
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL age_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_full();
        exp_t e;
        bus.disp_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_issue(4'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 4'd0, 1'b0, 4'd0);
            push_exp(4'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
            tick();
        end
        checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
            errors++; $display("[TB] FAIL full_flag: got count=%0d full=%b expected 8 and 1", bus.count, bus.full);
        end
        drive_issue(4'd9, 32'h999, 32'h999, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        bus.issue_valid = 1'b0;
        checks++; if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL full_drop: got count=%0d expected 8", bus.count); end
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_rob !== 4'd0 || bus.disp_v1 !== 32'h100) begin
            errors++; $display("[TB] FAIL full_hold: got valid=%b rob=%0d v1=%h expected 1, 0, 00000100", bus.disp_valid, bus.disp_rob, bus.disp_v1);
        end
        bus.disp_ready = 1'b1;
        for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2) begin
                    errors++; $display("[TB] FAIL full_drain: got rob=%0d v1=%h v2=%h expected rob=%0d v1=%h v2=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, e.rob, e.v1, e.v2);
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL full_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
        checks++; if (bus.count !== 4'd0 || bus.full !== 1'b0 || bus.disp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL full_empty: got count=%0d full=%b valid=%b expected 0, 0, 0", bus.count, bus.full, bus.disp_valid);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        rdy_in = 1'b0;
        drive_issue(4'd6, 32'h60, 32'h61, 1'b0, 4'd0, 1'b0, 4'd0);
        push_exp(4'd6, 32'h60, 32'h61);
        tick();
        tick();
        checks++; if (bus.count !== 4'd0 || bus.disp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_freeze: got count=%0d valid=%b expected 0 and 0", bus.count, bus.disp_valid);
        end
        rdy_in = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
            if (bus.disp_valid) begin
                e = sbq.pop_front();
                checks++;
                if (bus.disp_rob !== e.rob || bus.disp_v1 !== e.v1 || bus.disp_v2 !== e.v2) begin
                    errors++; $display("[TB] FAIL stall_dispatch: got rob=%0d v1=%h v2=%h expected rob=%0d v1=%h v2=%h",
                        bus.disp_rob, bus.disp_v1, bus.disp_v2, e.rob, e.v1, e.v2);
                end
            end
            tick();
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL stall_timeout: pending=%0d expected 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_flush();
        bus.disp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_issue(4'(i + 1), 32'h40 + 32'(i), 32'h50, 1'b0, 4'd0, 1'b0, 4'd0);
            tick();
        end
        checks++; if (bus.count !== 4'd4 || bus.disp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_setup: got count=%0d valid=%b expected 4 and 1", bus.count, bus.disp_valid);
        end
        rob_clear_up = 1'b1;
        drive_issue(4'd10, 32'hA0, 32'hA1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        rob_clear_up    = 1'b0;
        bus.issue_valid = 1'b0;
        checks++; if (bus.count !== 4'd0 || bus.disp_valid !== 1'b0 || bus.full !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_clear: got count=%0d valid=%b full=%b expected 0, 0, 0", bus.count, bus.disp_valid, bus.full);
        end
        bus.disp_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.count !== 4'd0 || bus.disp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_no_ghost: got count=%0d valid=%b expected 0 and 0", bus.count, bus.disp_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.disp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_issue(4'(i + 8), 32'h70 + 32'(i), 32'h80, 1'b0, 4'd0, 1'b0, 4'd0);
            tick();
        end
        bus.issue_valid = 1'b0;
        checks++; if (bus.count !== 4'd4 || bus.disp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_setup: got count=%0d valid=%b expected 4 and 1", bus.count, bus.disp_valid);
        end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0 || bus.disp_valid !== 1'b0 || bus.full !== 1'b0 || bus.disp_rob !== 4'd0) begin
            errors++; $display("[TB] FAIL rstmid_async: got count=%0d valid=%b full=%b rob=%0d expected 0, 0, 0, 0",
                bus.count, bus.disp_valid, bus.full, bus.disp_rob);
        end
        tick();
        rst_in         = 1'b0;
        bus.disp_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.count !== 4'd0 || bus.disp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_after: got count=%0d valid=%b expected 0 and 0", bus.count, bus.disp_valid);
        end
    endtask

    initial begin
        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        rob_clear_up = 1'b0;
        drive_idle();
        $display("[TB] starting rs_multi_cdb bench");
        test_reset();
        test_single();
        test_wakeup();
        test_bypass();
        test_cdb_priority();
        test_age_order();
        test_full();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to complete");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/rs_multi_cdb.md
RS_MULTI_CDB -- requirements
Module: rs_multi_cdb

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two, 2..32).
REQ-002 SHALL have parameter ROB_BITS, default 4, ROB tag width.
REQ-003 SHALL have parameter NUM_CDB, default 2, number of broadcast ports.
REQ-004 SHALL have port clk_in  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rdy_in  input  1  global stall when low.
REQ-007 SHALL have port rob_clear_up  input  1  synchronous flush.
REQ-008 SHALL have ports issue_valid 1, issue_op_type 7, issue_op 3, issue_alt 1 (inst[30]), issue_v1 32, issue_v2 32, issue_dep1 1, issue_dep2 1, issue_q1 ROB_BITS, issue_q2 ROB_BITS, issue_rd_rob ROB_BITS, issue_pc 32, all inputs.
REQ-009 SHALL have ports cdb_valid NUM_CDB, cdb_rob NUM_CDB*ROB_BITS, cdb_value NUM_CDB*32, all inputs, port k in slice k.
REQ-010 SHALL have outputs disp_valid 1, disp_op_type 7, disp_op 3, disp_alt 1, disp_v1 32, disp_v2 32, disp_rob ROB_BITS, disp_pc 32; input disp_ready 1.
REQ-011 SHALL have outputs full 1 and count $clog2(RS_SIZE+1).

Function
REQ-012 Entry ready = busy, no dep1, no dep2, all from registered state.
REQ-013 Issue SHALL write the lowest-index free entry when issue_valid && !full; issue_valid while full SHALL be ignored.
REQ-014 full SHALL equal (count==RS_SIZE) from registered count; a same-cycle dispatch SHALL NOT unblock an issue.
REQ-015 Each valid CDB port SHALL wake any busy entry whose pending q1/q2 equals its tag, writing the value and clearing dep.
REQ-016 Issue bypass: an issued operand with dep set whose tag matches a valid CDB port that cycle SHALL be stored ready with that value.
REQ-017 Multiple CDB ports matching one tag: the lowest port index SHALL win.
REQ-018 Selection SHALL pick the oldest ready entry by issue order (age matrix), never lowest-index.
REQ-019 Dispatch output SHALL be a one-deep register: load when empty or disp_ready high; selected entry freed on the same edge.
REQ-020 While disp_valid && !disp_ready, disp_* SHALL hold stable and no entry SHALL be selected.
REQ-021 Latency: entry ready at edge t (issue or wakeup) SHALL appear on disp_* after edge t+1 at earliest.
REQ-022 count SHALL be +1 on issue, -1 on dispatch load, unchanged when both occur.
REQ-023 rob_clear_up SHALL clear all busy, disp_valid, count and age state on the next edge, overriding issue, wakeup and dispatch.
REQ-024 rdy_in low SHALL freeze all state; disp_ready SHALL be ignored that cycle.

Reset
REQ-025 rst_in high SHALL immediately clear busy, deps, age matrix, count to 0, disp_valid to 0, all disp_* data to 0, full to 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries and any held dispatch with no partial completion.

Structure
REQ-027 ROB_BITS default, RS_SIZE default and the 7-bit op_type codes SHALL live in the shared constants package.
REQ-028 Oldest-ready select and lowest-free pick SHALL be one sub-module, rs_age_picker, combinational, parametrised by RS_SIZE.
REQ-029 The ALU SHALL remain outside this block; rs_multi_cdb only buffers and dispatches.

Verification
REQ-030 Issue tag rd=3 with v1=5,v2=7 no deps, disp_ready=1 -> disp_valid one cycle later, disp_v1=5, disp_v2=7, disp_rob=3, count back to 0.
REQ-031 Issue A (dep1 q1=2), then B ready; CDB0 tag 2 value 0x10 -> B dispatched first, A next with disp_v1=0x10.
REQ-032 Issue with dep1 q1=6 while cdb_valid[1]=1, tag 6, value 0xAB -> entry stored ready, dispatched with disp_v1=0xAB, no extra wait.
REQ-033 Fill 8 entries, disp_ready=0 -> full=1, ninth issue dropped, disp_* stable; raise disp_ready -> one entry per cycle, oldest first, count 8->0.
REQ-034 4 entries busy plus held dispatch, assert rob_clear_up -> next cycle count=0, disp_valid=0, full=0; same with rst_in mid-cycle -> cleared asynchronously.
REQ-035 cdb_valid=2'b11 both tag 4, values 1 and 2, entry waiting on tag 4 -> captures 1.
